// File: rtl/vrp_dispatch.sv
// Valid-ready 1:WIDTH demultiplexer steered by dst_s; each lane owns a
// 2-entry FIFO so lane outputs are registered and rdy_s never sees v_rdy_m.
module vrp_dispatch #(
  parameter int WIDTH     = 8,
  parameter int PLD_WIDTH = 32,
  parameter int ID_WIDTH  = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vld_s,
  input  logic [PLD_WIDTH-1:0] pld_s,
  input  logic [ID_WIDTH-1:0]  dst_s,
  output logic                 rdy_s,
  output logic [WIDTH-1:0]     v_vld_m,
  output logic [PLD_WIDTH-1:0] v_pld_m [WIDTH-1:0],
  input  logic [WIDTH-1:0]     v_rdy_m,
  output logic                 err_drop
);

  localparam logic [ID_WIDTH:0] NUM_LANES = (ID_WIDTH + 1)'(WIDTH);

  logic             dst_ok;
  logic             fire_s;
  logic [WIDTH-1:0] lane_sel;
  logic [WIDTH-1:0] lane_full;
  logic             err_drop_q;
  logic             err_drop_d;

  assign dst_ok = ({1'b0, dst_s} < NUM_LANES);

  // Only registered lane counts feed ready; a popping lane does not free space this cycle.
  always_comb begin
    rdy_s      = ~rst & (~dst_ok | ~|(lane_sel & lane_full));
    fire_s     = vld_s & rdy_s;
    err_drop_d = fire_s & ~dst_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_drop_q <= 1'b0;
    end else begin
      err_drop_q <= err_drop_d;
    end
  end

  assign err_drop = err_drop_q;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
    logic [1:0]           cnt_q;
    logic [1:0]           cnt_d;
    logic [1:0]           wr_slot;
    logic [PLD_WIDTH-1:0] slot0_q;
    logic [PLD_WIDTH-1:0] slot1_q;
    logic                 push;
    logic                 pop;

    assign lane_sel[gi]  = dst_ok && (dst_s == ID_WIDTH'(gi));
    assign lane_full[gi] = (cnt_q == 2'd2);
    assign push          = fire_s & lane_sel[gi];
    assign pop           = v_vld_m[gi] & v_rdy_m[gi];

    always_comb begin
      cnt_d   = cnt_q;
      wr_slot = pop ? (cnt_q - 2'd1) : cnt_q;
      if (push && !pop) begin
        cnt_d = (cnt_q == 2'd2) ? 2'd2 : (cnt_q + 2'd1);
      end else if (pop && !push) begin
        cnt_d = (cnt_q == 2'd0) ? 2'd0 : (cnt_q - 2'd1);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= 2'd0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    // Payload storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
      if (push && wr_slot == 2'd0) begin
        slot0_q <= pld_s;
      end else if (pop) begin
        slot0_q <= slot1_q;
      end
      if (push && wr_slot == 2'd1) begin
        slot1_q <= pld_s;
      end
    end

    assign v_vld_m[gi] = (cnt_q != 2'd0);
    assign v_pld_m[gi] = slot0_q;

    a_no_push_full : assert property (@(posedge clk) disable iff (rst)
      !(push && cnt_q == 2'd2));
    a_no_pop_empty : assert property (@(posedge clk) disable iff (rst)
      !(pop && cnt_q == 2'd0));
  end

endmodule

// File: tb/tb_vrp_dispatch.sv
// Bench for vrp_dispatch: per-lane scoreboard queues checked by a monitor,
// plus one task per scenario with inline checks. A 6-lane copy covers out-of-range dst.
module tb_vrp_dispatch;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld_s;
  logic [31:0] pld_s;
  logic [2:0]  dst_s;
  logic        rdy_s;
  logic [7:0]  v_vld_m;
  logic [31:0] v_pld_m [7:0];
  logic [7:0]  v_rdy_m;
  logic        err_drop;

  logic        vld6;
  logic [31:0] pld6;
  logic [2:0]  dst6;
  logic        rdy6;
  logic [5:0]  vv6;
  logic [31:0] vp6 [5:0];
  logic [5:0]  vr6;
  logic        err6;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [8][$];

  vrp_dispatch #(.WIDTH(8), .PLD_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .vld_s(vld_s), .pld_s(pld_s), .dst_s(dst_s),
    .rdy_s(rdy_s), .v_vld_m(v_vld_m), .v_pld_m(v_pld_m), .v_rdy_m(v_rdy_m),
    .err_drop(err_drop)
  );

  vrp_dispatch #(.WIDTH(6), .PLD_WIDTH(32)) dut6 (
    .clk(clk), .rst(rst), .vld_s(vld6), .pld_s(pld6), .dst_s(dst6),
    .rdy_s(rdy6), .v_vld_m(vv6), .v_pld_m(vp6), .v_rdy_m(vr6),
    .err_drop(err6)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every lane handshake is checked against the queued acceptance order.
  task automatic monitor();
    logic [31:0] e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        if (v_vld_m[i] && v_rdy_m[i]) begin
          checks++;
          if (exp_q[i].size() == 0) begin
            errors++;
            $display("FAIL lane%0d_unexpected got %h expected no beat", i, v_pld_m[i]);
          end else begin
            e = exp_q[i].pop_front();
            if (v_pld_m[i] !== e) begin
              errors++;
              $display("FAIL lane%0d_payload got %h expected %h", i, v_pld_m[i], e);
            end else begin
              $display("lane %0d out %h", i, v_pld_m[i]);
            end
          end
        end
      end
    end
  endtask

  task automatic send(input logic [2:0] d, input logic [31:0] p,
                      output logic acc, output logic [7:0] vv);
    vld_s = 1'b1;
    dst_s = d;
    pld_s = p;
    @(negedge clk);
    acc = rdy_s;
    vv  = v_vld_m;
    if (acc) exp_q[d].push_back(p);
    $display("send dst %0d pld %h accepted %0b", d, p, acc);
    tick();
    vld_s = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (rdy_s !== 1'b0 || rdy6 !== 1'b0) begin
      errors++;
      $display("FAIL reset_rdy got %b/%b expected 0/0", rdy_s, rdy6);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (v_vld_m !== 8'h00 || err_drop !== 1'b0 || rdy_s !== 1'b1 || vv6 !== 6'h00) begin
      errors++;
      $display("FAIL reset_state got vld %h err %b rdy %b vv6 %h expected 00 0 1 00",
               v_vld_m, err_drop, rdy_s, vv6);
    end
    tick();
  endtask

  task automatic test_single_beat();
    logic acc;
    logic [7:0] vv;
    v_rdy_m = 8'hFF;
    send(3'd3, 32'hA5A5_0003, acc, vv);
    checks++;
    if (acc !== 1'b1 || vv !== 8'h00) begin
      errors++;
      $display("FAIL single_accept got acc %b vld %h expected 1 00", acc, vv);
    end
    @(negedge clk);
    checks++;
    if (v_vld_m !== 8'h08 || err_drop !== 1'b0) begin
      errors++;
      $display("FAIL single_vld got %h err %b expected 08 0", v_vld_m, err_drop);
    end
    tick();
    @(negedge clk);
    checks++;
    if (v_vld_m !== 8'h00) begin
      errors++;
      $display("FAIL single_clear got %h expected 00", v_vld_m);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic acc0, acc1;
    logic [7:0] vv;
    v_rdy_m = 8'hFB;
    send(3'd2, 32'h11, acc0, vv);
    send(3'd2, 32'h22, acc1, vv);
    checks++;
    if (acc0 !== 1'b1 || acc1 !== 1'b1) begin
      errors++;
      $display("FAIL bp_fill got %b%b expected 11", acc0, acc1);
    end
    vld_s = 1'b1;
    dst_s = 3'd2;
    pld_s = 32'h33;
    @(negedge clk);
    checks++;
    if (rdy_s !== 1'b0) begin
      errors++;
      $display("FAIL bp_full_rdy got %b expected 0", rdy_s);
    end
    tick();
    v_rdy_m = 8'hFF;
    @(negedge clk);
    checks++;
    if (rdy_s !== 1'b0 || v_vld_m[2] !== 1'b1) begin
      errors++;
      $display("FAIL bp_no_bypass got rdy %b vld %b expected 0 1", rdy_s, v_vld_m[2]);
    end
    tick();
    @(negedge clk);
    checks++;
    if (rdy_s !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_rdy got %b expected 1", rdy_s);
    end else begin
      exp_q[2].push_back(32'h33);
    end
    tick();
    vld_s = 1'b0;
    @(negedge clk);
    checks++;
    if (v_vld_m[2] !== 1'b1 || v_pld_m[2] !== 32'h33) begin
      errors++;
      $display("FAIL bp_third got vld %b pld %h expected 1 00000033", v_vld_m[2], v_pld_m[2]);
    end
    tick();
    @(negedge clk);
    checks++;
    if (v_vld_m !== 8'h00) begin
      errors++;
      $display("FAIL bp_drained got %h expected 00", v_vld_m);
    end
    tick();
  endtask

  task automatic test_lane_independence();
    logic acc;
    logic [7:0] vv;
    v_rdy_m = 8'hDF;
    send(3'd5, 32'h55, acc, vv);
    send(3'd5, 32'h56, acc, vv);
    for (int k = 0; k < 4; k++) begin
      send(3'(k % 2), 32'h100 + 32'(k), acc, vv);
      checks++;
      if (acc !== 1'b1 || v_vld_m[5] !== 1'b1 || v_pld_m[5] !== 32'h55) begin
        errors++;
        $display("FAIL indep_%0d got acc %b vld5 %b pld5 %h expected 1 1 00000055",
                 k, acc, v_vld_m[5], v_pld_m[5]);
      end
    end
    vld_s = 1'b1;
    dst_s = 3'd5;
    pld_s = 32'h57;
    @(negedge clk);
    checks++;
    if (rdy_s !== 1'b0) begin
      errors++;
      $display("FAIL indep_full_rdy got %b expected 0", rdy_s);
    end
    tick();
    vld_s = 1'b0;
    v_rdy_m = 8'hFF;
    for (int k = 0; k < 3; k++) tick();
  endtask

  task automatic test_full_throughput();
    logic acc;
    logic [7:0] vv;
    v_rdy_m = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      send(3'd7, 32'h7000 + 32'(i), acc, vv);
      checks++;
      if (acc !== 1'b1 || vv[7] !== (i != 0)) begin
        errors++;
        $display("FAIL tput_%0d got acc %b vld7 %b expected 1 %0b", i, acc, vv[7], i != 0);
      end
    end
    @(negedge clk);
    checks++;
    if (v_vld_m[7] !== 1'b1) begin
      errors++;
      $display("FAIL tput_last got %b expected 1", v_vld_m[7]);
    end
    tick();
    @(negedge clk);
    checks++;
    if (v_vld_m[7] !== 1'b0) begin
      errors++;
      $display("FAIL tput_end got %b expected 0", v_vld_m[7]);
    end
    tick();
  endtask

  task automatic test_out_of_range();
    vr6  = 6'h3F;
    vld6 = 1'b1;
    dst6 = 3'd6;
    pld6 = 32'hDEAD;
    @(negedge clk);
    checks++;
    if (rdy6 !== 1'b1 || err6 !== 1'b0) begin
      errors++;
      $display("FAIL oor_accept got rdy %b err %b expected 1 0", rdy6, err6);
    end
    tick();
    vld6 = 1'b0;
    @(negedge clk);
    checks++;
    if (err6 !== 1'b1 || vv6 !== 6'h00) begin
      errors++;
      $display("FAIL oor_pulse got err %b vld %h expected 1 00", err6, vv6);
    end
    tick();
    @(negedge clk);
    checks++;
    if (err6 !== 1'b0 || vv6 !== 6'h00) begin
      errors++;
      $display("FAIL oor_pulse_end got err %b vld %h expected 0 00", err6, vv6);
    end
    tick();
    vld6 = 1'b1;
    dst6 = 3'd5;
    pld6 = 32'h5;
    @(negedge clk);
    checks++;
    if (rdy6 !== 1'b1) begin
      errors++;
      $display("FAIL w6_accept got %b expected 1", rdy6);
    end
    tick();
    vld6 = 1'b0;
    @(negedge clk);
    checks++;
    if (vv6 !== 6'h20 || vp6[5] !== 32'h5 || err6 !== 1'b0) begin
      errors++;
      $display("FAIL w6_lane5 got vld %h pld %h err %b expected 20 00000005 0", vv6, vp6[5], err6);
    end
    tick();
  endtask

  task automatic test_reset_mid_op();
    logic acc;
    logic [7:0] vv;
    v_rdy_m = 8'h00;
    send(3'd0, 32'hA0, acc, vv);
    send(3'd0, 32'hA1, acc, vv);
    send(3'd4, 32'hC0, acc, vv);
    checks++;
    if (v_vld_m !== 8'h11) begin
      errors++;
      $display("FAIL rmo_loaded got %h expected 11", v_vld_m);
    end
    rst   = 1'b1;
    vld_s = 1'b1;
    dst_s = 3'd0;
    pld_s = 32'hBAD;
    @(negedge clk);
    checks++;
    if (rdy_s !== 1'b0) begin
      errors++;
      $display("FAIL rmo_rdy_in_reset got %b expected 0", rdy_s);
    end
    tick();
    rst   = 1'b0;
    vld_s = 1'b0;
    for (int i = 0; i < 8; i++) exp_q[i].delete();
    @(negedge clk);
    checks++;
    if (v_vld_m !== 8'h00 || rdy_s !== 1'b1) begin
      errors++;
      $display("FAIL rmo_cleared got vld %h rdy %b expected 00 1", v_vld_m, rdy_s);
    end
    tick();
    v_rdy_m = 8'hFF;
    send(3'd0, 32'h600D, acc, vv);
    checks++;
    if (acc !== 1'b1 || vv !== 8'h00) begin
      errors++;
      $display("FAIL rmo_send got acc %b vld %h expected 1 00", acc, vv);
    end
    @(negedge clk);
    checks++;
    if (v_vld_m !== 8'h01) begin
      errors++;
      $display("FAIL rmo_alone got %h expected 01", v_vld_m);
    end
    tick();
    @(negedge clk);
    checks++;
    if (v_vld_m !== 8'h00) begin
      errors++;
      $display("FAIL rmo_end got %h expected 00", v_vld_m);
    end
    tick();
  endtask

  task automatic test_scoreboard_empty();
    int left;
    left = 0;
    for (int i = 0; i < 8; i++) left += exp_q[i].size();
    checks++;
    if (left !== 0) begin
      errors++;
      $display("FAIL scoreboard_empty got %0d pending expected 0", left);
    end
  endtask

  initial begin
    rst     = 1'b1;
    vld_s   = 1'b0;
    pld_s   = '0;
    dst_s   = '0;
    v_rdy_m = 8'hFF;
    vld6    = 1'b0;
    pld6    = '0;
    dst6    = '0;
    vr6     = 6'h3F;
    fork
      monitor();
    join_none
    tick();
    test_reset();
    test_single_beat();
    test_backpressure();
    test_lane_independence();
    test_full_throughput();
    test_out_of_range();
    test_reset_mid_op();
    test_scoreboard_empty();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vrp_dispatch.md
Name: vrp_dispatch

Overview:
- Valid-ready demultiplexer: one upstream source fans out to WIDTH downstream sinks, steered by a destination index carried with each beat.
- Mirror of the fixed-priority N:1 valid-ready arbiter. Used on the return/response side of the same fabric.
- Each output lane owns a 2-entry buffer. Result: full throughput per lane, registered outputs, and no combinational path from any v_rdy_m to rdy_s.

Parameters:
- WIDTH, 8, number of output lanes (>=2).
- PLD_WIDTH, 32, payload width in bits.
- ID_WIDTH, $clog2(WIDTH), width of destination index.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- vld_s  input  1  upstream beat valid.
- pld_s  input  PLD_WIDTH  upstream payload.
- dst_s  input  ID_WIDTH  destination lane index of the beat.
- rdy_s  output  1  upstream ready.
- v_vld_m  output  WIDTH  per-lane valid.
- v_pld_m  output  PLD_WIDTH x WIDTH (unpacked [WIDTH-1:0])  per-lane payload.
- v_rdy_m  input  WIDTH  per-lane downstream ready.
- err_drop  output  1  one-cycle pulse: a beat with out-of-range dst_s was accepted and discarded.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset state:
  - All lane counts = 0.
  - v_vld_m = 0. err_drop = 0. rdy_s = 1 in the cycle after reset deasserts.
  - Payload storage is not reset. v_pld_m[i] is don't-care while v_vld_m[i]=0.
- Lane state: per lane, a 2-entry FIFO. Head is at slot 0; count is 0..2; v_vld_m[i] = (count_i != 0); v_pld_m[i] = slot0_i.
- Ready:
  - rdy_s = (dst_s >= WIDTH) | (count[dst_s] < 2).
  - rdy_s is a function of registered count and dst_s only. It does not depend on v_rdy_m; no pop-through bypass.
  - rdy_s may depend on dst_s combinationally. Upstream must hold dst_s/pld_s stable while vld_s & ~rdy_s.
- Push: fire_s = vld_s & rdy_s. If dst_s < WIDTH, write pld_s into lane dst_s at slot[count], or at slot[count-1] if that lane pops in the same cycle.
- Pop: fire_m[i] = v_vld_m[i] & v_rdy_m[i]. Slot1 shifts to slot0 and count decrements.
- Simultaneous push and pop, same lane:
  - count unchanged.
  - count=1: new data goes to slot0.
  - count=2: impossible, since rdy_s=0.
- Latency: an accepted beat appears on v_vld_m[dst] on the next cycle at the earliest (1-cycle latency). Never combinational.
- Throughput: one beat per cycle into any lane while that lane drains every cycle. Lanes are independent: a full lane blocks only beats addressed to it (head-of-line at the single input is inherent).
- Ordering: beats to the same lane leave in acceptance order.
- Out-of-range dst (only possible when WIDTH is not a power of 2): always accepted (rdy_s=1), discarded, err_drop=1 next cycle for one cycle. No lane state changes.
- Valid stability: once v_vld_m[i]=1 it stays high and v_pld_m[i] stays stable until fire_m[i].
- Reset mid-operation: on the next edge all buffered beats are discarded, counts clear and err_drop clears. Beats presented in the reset cycle are not accepted. rdy_s is forced to 0 while rst=1.
- Counts use 2-bit saturating logic. Pushing while count=2 or popping while count=0 cannot occur; assertions flag either.

Test Plan:
1. Single beat: after reset, vld_s=1, dst_s=3, pld_s=0xA5A5_0003 for 1 cycle, v_rdy_m=all 1 -> v_vld_m=8'h08 with v_pld_m[3]=0xA5A5_0003 exactly next cycle, then 0; no other lane asserts.
2. Backpressure fill: v_rdy_m[2]=0, send 3 beats to dst 2 (0x11,0x22,0x33) -> first two accepted, rdy_s=0 on third. Release v_rdy_m[2] -> lane emits 0x11, 0x22, then 0x33 one cycle later, order preserved.
3. Lane independence: lane 5 full (v_rdy_m[5]=0), stream dst 0,1,0,1 -> all accepted back-to-back with rdy_s=1; lane 5 remains at count 2 and value stable.
4. Full throughput: 16 consecutive beats to dst 7 with v_rdy_m[7]=1 -> rdy_s never drops, v_vld_m[7] high for 16 consecutive cycles starting 1 cycle after the first beat, payloads in order.
5. Out-of-range: WIDTH=6, dst_s=6, pld=0xDEAD -> rdy_s=1, err_drop pulses one cycle later for exactly one cycle, v_vld_m stays 0.
6. Reset mid-operation: lanes 0 and 4 holding 2 and 1 beats, assert rst 1 cycle -> v_vld_m=0 next cycle, rdy_s=0 during reset and 1 afterwards; the first beat after reset to dst 0 emerges alone with no stale data.
